// File: rtl/mmu_arb_pkg.sv
// Shared types and default widths for the MMU port arbiter.
package mmu_arb_pkg;

   localparam int MMU_ADDR_W    = 32;
   localparam int MMU_DATA_W    = 32;
   localparam int MMU_BURST_MAX = 16;
   localparam int BURST_CNT_W   = $clog2(MMU_BURST_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      POST,
      LOCKED
   } arb_state_t;

   // Command fields latched from the winning requester at issue time
   typedef struct packed {
      logic [MMU_ADDR_W-1:0] ptr;
      logic [MMU_DATA_W-1:0] wdata;
      logic                  we;
      logic                  wt;
      logic                  rt;
   } req_cmd_t;

endpackage

// File: rtl/mmu_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after index 'last', wrapping.
module rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] last,
   output logic [N-1:0]     pick,
   output logic             any
);

   logic             found;
   logic [IDX_W-1:0] idx;

   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IDX_W'((int'(last) + k) % N);
         if (!found && req[idx]) begin
            pick[idx] = 1'b1;
            found     = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/mmu_arbiter.sv
// Round-robin arbiter sharing one MMU port between NUM_REQ requesters, with burst locking.
// Command field widths follow mmu_arb_pkg; ADDR_W/DATA_W must match MMU_ADDR_W/MMU_DATA_W.
//
// state  | meaning
// IDLE   | no owner, gnt=0; picks next requester round-robin
// ACCESS | command on the MMU port, waiting for mmu_done
// POST   | req_done pulse, enables low; decides keep-lock or release
// LOCKED | owner keeps gnt, next access issues when its req_valid is set
module mmu_arbiter
   import mmu_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int ADDR_W    = MMU_ADDR_W,
   parameter int DATA_W    = MMU_DATA_W,
   parameter int BURST_MAX = MMU_BURST_MAX
) (
   input  logic                      clk,
   input  logic                      rst_l,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ-1:0]        req_wt,
   input  logic [NUM_REQ-1:0]        req_rt,
   input  logic [NUM_REQ*ADDR_W-1:0] req_ptr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        req_done,
   output logic [DATA_W-1:0]         rdata,
   output logic                      busy,
   output logic [ADDR_W-1:0]         mmu_ptr,
   output logic                      mmu_r_en,
   output logic                      mmu_w_en,
   output logic                      mmu_avail,
   output logic                      mmu_wt,
   output logic                      mmu_rt,
   output logic [DATA_W-1:0]         mmu_data_store,
   input  logic [DATA_W-1:0]         mmu_data_load,
   input  logic                      mmu_done
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(BURST_MAX + 1);
   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

   arb_state_t         state_q, state_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               r_en_q, r_en_d;
   logic               w_en_q, w_en_d;
   logic               avail_q;
   logic               busy_q;
   req_cmd_t           cmd_q, cmd_d, sel_cmd;
   logic [IDX_W-1:0]   owner_q, owner_d;
   logic [IDX_W-1:0]   rr_last_q, rr_last_d;
   logic [CNT_W-1:0]   burst_q, burst_d;

   logic [NUM_REQ-1:0] pick;
   logic               any_req;
   logic [IDX_W-1:0]   pick_idx;
   logic [IDX_W-1:0]   sel_idx;
   logic               others_pending;
   logic               do_issue;
   logic               do_rel;

   rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
      .req  (req_valid),
      .last (rr_last_q),
      .pick (pick),
      .any  (any_req)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick[i]) pick_idx = IDX_W'(i);
      end
   end

   // In IDLE the command comes from the round-robin winner, in LOCKED from the owner
   always_comb begin
      sel_idx       = (state_q == IDLE) ? pick_idx : owner_q;
      sel_cmd.ptr   = req_ptr[int'(sel_idx)*ADDR_W +: ADDR_W];
      sel_cmd.wdata = req_wdata[int'(sel_idx)*DATA_W +: DATA_W];
      sel_cmd.we    = req_we[sel_idx];
      sel_cmd.wt    = req_wt[sel_idx];
      sel_cmd.rt    = req_rt[sel_idx];
   end

   always_comb begin
      state_d        = state_q;
      gnt_d          = gnt_q;
      done_d         = '0;
      rdata_d        = rdata_q;
      r_en_d         = r_en_q;
      w_en_d         = w_en_q;
      cmd_d          = cmd_q;
      owner_d        = owner_q;
      rr_last_d      = rr_last_q;
      burst_d        = burst_q;
      do_issue       = 1'b0;
      do_rel         = 1'b0;
      others_pending = |(req_valid & ~gnt_q);

      case (state_q)
         IDLE: begin
            if (any_req) begin
               do_issue = 1'b1;
               gnt_d    = pick;
               owner_d  = pick_idx;
            end
         end
         ACCESS: begin
            if (mmu_done) begin
               r_en_d  = 1'b0;
               w_en_d  = 1'b0;
               done_d  = gnt_q;
               state_d = POST;
               if (!cmd_q.we) rdata_d = mmu_data_load;
               if (burst_q < BURST_LIM) burst_d = burst_q + CNT_W'(1);
            end
         end
         POST: begin
            if (req_lock[owner_q] && !(others_pending && (burst_q >= BURST_LIM)))
               state_d = LOCKED;
            else
               do_rel = 1'b1;
         end
         LOCKED: begin
            if (req_valid[owner_q])
               do_issue = 1'b1;
            else if (!req_lock[owner_q])
               do_rel = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (do_issue) begin
         cmd_d   = sel_cmd;
         r_en_d  = !sel_cmd.we;
         w_en_d  = sel_cmd.we;
         state_d = ACCESS;
      end

      if (do_rel) begin
         state_d   = IDLE;
         gnt_d     = '0;
         rr_last_d = owner_q;
         burst_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         r_en_q    <= 1'b0;
         w_en_q    <= 1'b0;
         avail_q   <= 1'b0;
         busy_q    <= 1'b0;
         cmd_q     <= '0;
         owner_q   <= '0;
         rr_last_q <= IDX_W'(NUM_REQ - 1);
         burst_q   <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         r_en_q    <= r_en_d;
         w_en_q    <= w_en_d;
         avail_q   <= r_en_d | w_en_d;
         busy_q    <= (state_d != IDLE);
         cmd_q     <= cmd_d;
         owner_q   <= owner_d;
         rr_last_q <= rr_last_d;
         burst_q   <= burst_d;
      end
   end

   assign gnt            = gnt_q;
   assign req_done       = done_q;
   assign rdata          = rdata_q;
   assign busy           = busy_q;
   assign mmu_r_en       = r_en_q;
   assign mmu_w_en       = w_en_q;
   assign mmu_avail      = avail_q;
   assign mmu_ptr        = cmd_q.ptr;
   assign mmu_data_store = cmd_q.wdata;
   assign mmu_wt         = cmd_q.wt;
   assign mmu_rt         = cmd_q.rt;

endmodule

// File: tb/tb_mmu_arbiter.sv
// Bench for mmu_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_mmu_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BM = 16;

   logic            clk = 1'b0;
   logic            rst_l = 1'b0;
   logic [N-1:0]    req_valid = '0, req_lock = '0, req_we = '0, req_wt = '0, req_rt = '0;
   logic [N*AW-1:0] req_ptr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]    gnt, req_done;
   logic [DW-1:0]   rdata, mmu_data_store;
   logic [DW-1:0]   mmu_data_load = '0;
   logic [AW-1:0]   mmu_ptr;
   logic            busy, mmu_r_en, mmu_w_en, mmu_avail, mmu_wt, mmu_rt;
   logic            mmu_done = 1'b0;

   int checks = 0;
   int errors = 0;

   mmu_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
      .clk(clk), .rst_l(rst_l),
      .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
      .req_wt(req_wt), .req_rt(req_rt), .req_ptr(req_ptr), .req_wdata(req_wdata),
      .gnt(gnt), .req_done(req_done), .rdata(rdata), .busy(busy),
      .mmu_ptr(mmu_ptr), .mmu_r_en(mmu_r_en), .mmu_w_en(mmu_w_en), .mmu_avail(mmu_avail),
      .mmu_wt(mmu_wt), .mmu_rt(mmu_rt), .mmu_data_store(mmu_data_store),
      .mmu_data_load(mmu_data_load), .mmu_done(mmu_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // MMU responder: done after 'lat' enabled cycles; 'spur' forces done while idle
   int          lat = 2;
   int          rsp_cnt = 0;
   logic [7:0]  rsp_n = '0;
   logic [31:0] rd_word = 32'h1234_0000;
   bit          fixed_rd = 1'b0;
   bit          spur = 1'b0;

   always begin
      @(negedge clk);
      #1;
      if (rst_l && (mmu_r_en || mmu_w_en)) begin
         rsp_cnt++;
         if (rsp_cnt == lat) begin
            rsp_n++;
            mmu_done      = 1'b1;
            mmu_data_load = fixed_rd ? rd_word : (rd_word ^ {24'h0, rsp_n});
         end else begin
            mmu_done = 1'b0;
         end
      end else begin
         rsp_cnt  = 0;
         mmu_done = spur;
      end
   end

   // Model: owner index (-1 = none), access in flight, post cycle, held command
   int          m_owner, m_last, m_burst;
   bit          m_access, m_post, m_we, m_wt, m_rt;
   logic [31:0] m_ptr, m_wd, m_rdata;
   logic [N-1:0] m_done;

   task automatic take(input int i);
      m_ptr = req_ptr[i*AW +: AW];
      m_wd  = req_wdata[i*DW +: DW];
      m_we  = req_we[i];
      m_wt  = req_wt[i];
      m_rt  = req_rt[i];
      m_access = 1'b1;
   endtask

   task automatic give_up();
      m_last  = m_owner;
      m_owner = -1;
      m_burst = 0;
   endtask

   always @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         m_owner = -1; m_last = N - 1; m_burst = 0;
         m_access = 0; m_post = 0; m_we = 0; m_wt = 0; m_rt = 0;
         m_ptr = '0; m_wd = '0; m_rdata = '0; m_done = '0;
      end else begin
         m_done = '0;
         if (m_owner < 0) begin
            for (int k = 1; k <= N; k++)
               if (m_owner < 0 && req_valid[(m_last + k) % N]) m_owner = (m_last + k) % N;
            if (m_owner >= 0) take(m_owner);
         end else if (m_access) begin
            if (mmu_done) begin
               m_access = 0;
               m_post   = 1;
               m_done   = N'(1 << m_owner);
               if (!m_we) m_rdata = mmu_data_load;
               m_burst  = (m_burst < BM) ? m_burst + 1 : BM;
            end
         end else if (m_post) begin
            m_post = 0;
            if (!(req_lock[m_owner] && !(((req_valid & ~N'(1 << m_owner)) != 0) && m_burst >= BM)))
               give_up();
         end else begin
            if (req_valid[m_owner]) take(m_owner);
            else if (!req_lock[m_owner]) give_up();
         end
      end
   end

   // Per-cycle compare against the model, plus invariants and a grant-order log
   int          glog[$];
   logic [N-1:0] prev_gnt = '0;
   logic [N-1:0] eg;

   always @(negedge clk) begin
      eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("req_done", 32'(req_done), 32'(m_done));
      chk("mmu_r_en", 32'(mmu_r_en), 32'(m_access && !m_we));
      chk("mmu_w_en", 32'(mmu_w_en), 32'(m_access && m_we));
      chk("mmu_avail", 32'(mmu_avail), 32'(m_access));
      chk("busy", 32'(busy), 32'(m_owner >= 0));
      if (m_access) begin
         chk("mmu_ptr", mmu_ptr, m_ptr);
         chk("mmu_wt", 32'(mmu_wt), 32'(m_wt));
         chk("mmu_rt", 32'(mmu_rt), 32'(m_rt));
         if (m_we) chk("mmu_data_store", mmu_data_store, m_wd);
      end
      if (m_done != 0) chk("rdata", rdata, m_rdata);
      chk("inv_rw_excl", 32'(mmu_r_en && mmu_w_en), 32'(0));
      chk("inv_gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
      chk("inv_done_onehot0", 32'($onehot0(req_done)), 32'(1));
      if (m_post) chk("inv_post_idle", 32'(mmu_avail), 32'(0));
      if (gnt != 0 && gnt != prev_gnt)
         for (int i = 0; i < N; i++) if (gnt[i]) glog.push_back(i);
      prev_gnt = gnt;
   end

   task automatic wait_for(input int kind, input int arg, input string nm, output int n);
      bit hit;
      n = 0;
      hit = 0;
      while (!hit && n < 500) begin
         @(negedge clk);
         case (kind)
            0: hit = mmu_r_en || mmu_w_en;
            1: hit = req_done[arg];
            2: hit = !busy;
            default: hit = gnt[arg];
         endcase
         n++;
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL %s timeout after %0d cycles", nm, n);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_l = 1'b0;
      @(negedge clk);
      rst_l = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, cnt, bad;
      bit seen, dropped;
      for (int i = 0; i < N; i++) begin
         req_ptr[i*AW +: AW]   = 32'h100 * i;
         req_wdata[i*DW +: DW] = 32'hA500_0000 | i;
      end
      req_we = 4'b1001;
      req_wt = 4'b0101;
      req_rt = 4'b0011;

      repeat (2) @(negedge clk);
      chk("reset_gnt", 32'(gnt), 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_avail", 32'(mmu_avail), 32'h0);
      rst_l = 1'b1;

      // Reset asserted mid-ACCESS (requester 0 write, MMU never answers)
      @(negedge clk);
      lat = 100;
      req_valid = 4'b0001;
      wait_for(0, 0, "t1_enable", n);
      chk("t1_w_en_up", 32'(mmu_w_en), 32'h1);
      #2 rst_l = 1'b0;
      #1;
      chk("t1_rst_w_en", 32'(mmu_w_en), 32'h0);
      chk("t1_rst_avail", 32'(mmu_avail), 32'h0);
      chk("t1_rst_gnt", 32'(gnt), 32'h0);
      chk("t1_rst_ptr", mmu_ptr, 32'h0);
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);
      rst_l = 1'b1;
      @(negedge clk);
      chk("t1_idle_busy", 32'(busy), 32'h0);

      // Single read from requester 1
      lat = 3;
      fixed_rd = 1'b1;
      rd_word = 32'hDEAD_BEEF;
      req_valid = 4'b0010;
      wait_for(0, 0, "t2_enable", n);
      chk("t2_enable_latency", n, 1);
      chk("t2_r_en", 32'(mmu_r_en), 32'h1);
      chk("t2_ptr", mmu_ptr, 32'h100);
      chk("t2_gnt", 32'(gnt), 32'h2);
      req_valid = '0;
      wait_for(1, 1, "t2_done", n);
      chk("t2_done_latency", n, 3);
      chk("t2_req_done", 32'(req_done), 32'h2);
      chk("t2_rdata", rdata, 32'hDEAD_BEEF);
      chk("t2_post_avail", 32'(mmu_avail), 32'h0);
      fixed_rd = 1'b0;
      rd_word = 32'h5500_0000;
      wait_for(2, 0, "t2_idle", n);

      // Fairness with all four requesting, no lock
      pulse_reset();
      lat = 1;
      glog.delete();
      req_valid = 4'b1111;
      n = 0;
      while (glog.size() < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      req_valid = '0;
      chk("t3_grant_count", glog.size() >= 5, 1);
      if (glog.size() >= 5) begin
         chk("t3_order0", glog[0], 0);
         chk("t3_order1", glog[1], 1);
         chk("t3_order2", glog[2], 2);
         chk("t3_order3", glog[3], 3);
         chk("t3_order4", glog[4], 0);
      end
      wait_for(2, 0, "t3_idle", n);

      // Burst: requester 2 locked, requester 0 pending from the first grant
      pulse_reset();
      req_lock = 4'b0100;
      req_valid = 4'b0100;
      wait_for(3, 2, "t4_gnt2", n);
      req_valid = 4'b0101;
      cnt = 0;
      n = 0;
      while (!gnt[0] && n < 1000) begin
         @(negedge clk);
         if (req_done[2]) cnt++;
         n++;
      end
      chk("t4_burst_len", cnt, 16);
      chk("t4_gnt_moves_to_0", 32'(gnt), 32'h1);
      req_valid[0] = 1'b0;
      n = 0;
      while (cnt < 20 && n < 1000) begin
         @(negedge clk);
         if (req_done[2]) cnt++;
         n++;
      end
      req_valid = '0;
      req_lock = '0;
      chk("t4_total", cnt, 20);
      wait_for(2, 0, "t4_idle", n);

      // Lock without contention: 40 accesses for requester 3, gnt never drops
      req_lock = 4'b1000;
      req_valid = 4'b1000;
      wait_for(3, 3, "t5_gnt3", n);
      cnt = 0;
      bad = 0;
      n = 0;
      while (cnt < 40 && n < 2000) begin
         @(negedge clk);
         if (gnt != 4'b1000) bad++;
         if (req_done[3]) cnt++;
         n++;
      end
      req_valid = '0;
      chk("t5_accesses", cnt, 40);
      chk("t5_gnt_drops", bad, 0);
      @(negedge clk);
      chk("t5_locked_gnt", 32'(gnt), 32'h8);
      req_lock = '0;
      @(negedge clk);
      chk("t5_release_gnt", 32'(gnt), 32'h0);
      chk("t5_release_busy", 32'(busy), 32'h0);

      // Spurious mmu_done while idle
      spur = 1'b1;
      @(negedge clk);
      spur = 1'b0;
      cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (req_done != 0 || busy) cnt++;
      end
      chk("t6_spurious", cnt, 0);

      // Owner keeps req_valid through POST: exactly one extra access
      lat = 2;
      req_valid = 4'b0010;
      cnt = 0;
      seen = 0;
      dropped = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (req_done[1]) begin
            cnt++;
            seen = 1;
         end else if (seen && mmu_r_en && !dropped) begin
            req_valid = '0;
            dropped = 1;
         end
      end
      chk("t6_overlap_count", cnt, 2);
      chk("t6_final_busy", 32'(busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
